// File: rtl/serial_word_transmit.sv
// Word-oriented 8N1 UART transmitter: sends a 32-bit word as four byte frames, MSB byte first.
// Optional even parity bit per byte when SERIAL_TX_PARITY_EN is defined.
module serial_word_transmit #(
    parameter int comm_clk_frequency = 100_000_000,
    parameter int baud_rate          = 115_200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send,
    input  logic [31:0] word,
    output logic        busy,
    output logic        TxD
);

    localparam int CPB_RAW = comm_clk_frequency / baud_rate;
    localparam int CPB     = (CPB_RAW < 2) ? 2 : CPB_RAW;
    localparam int CW      = $clog2(CPB);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   word_q;
    logic          tick;
    logic [7:0]    cur_byte;

    assign tick     = (cnt == CW'(CPB - 1));
    assign cur_byte = word_q[31:24];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            word_q   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE || tick)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (state == DATA && tick)
                bit_idx <= bit_idx + 3'd1;
            if (state == IDLE && send) begin
                word_q   <= word;
                byte_idx <= '0;
                bit_idx  <= '0;
            end else if (state == STOP && tick) begin
                // Next byte moves into the top slot so the data path never muxes on byte_idx.
                word_q   <= {word_q[23:0], 8'h00};
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        TxD        = 1'b1;
        case (state)
            IDLE: begin
                if (send) next_state = START;
            end
            START: begin
                TxD = 1'b0;
                if (tick) next_state = DATA;
            end
            DATA: begin
                TxD = cur_byte[bit_idx];
                if (tick && bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                TxD = ^cur_byte;
                if (tick) next_state = STOP;
            end
`endif
            STOP: begin
                if (tick) next_state = (byte_idx == 2'd3) ? IDLE : START;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_word_transmit.sv
// Directed bench for serial_word_transmit at 1 MHz / 115200 (8 cycles per bit) with a line receiver
// that decodes frames and compares them against a queue of expected bytes.
module tb_serial_word_transmit;

    localparam int CPB = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int WORD_CYC = 44 * CPB;
    localparam int STOP_K   = 10;
`else
    localparam int WORD_CYC = 40 * CPB;
    localparam int STOP_K   = 9;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        send;
    logic [31:0] word;
    logic        busy;
    logic        TxD;

    serial_word_transmit #(
        .comm_clk_frequency(1_000_000),
        .baud_rate         (115_200)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .send (send),
        .word (word),
        .busy (busy),
        .TxD  (TxD)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int rx_frames = 0;
    int dropped   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line receiver: position counted from the first negedge that sees the start bit low,
    // each bit sampled mid-period.
    bit         rx_on = 0;
    int         rx_pos;
    logic [7:0] rx_byte;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (TxD === 1'b0) begin
                rx_on  = 1;
                rx_pos = 0;
            end
        end else begin
            rx_pos++;
            if (rx_pos % CPB == CPB / 2) begin
                int k;
                k = rx_pos / CPB;
                if (k == 0) check("rx_start_bit", TxD, 1'b0);
                else if (k <= 8) rx_byte[k-1] = TxD;
`ifdef SERIAL_TX_PARITY_EN
                else if (k == 9) check("rx_parity", TxD, ^rx_byte);
`endif
                if (k == STOP_K) begin
                    check("rx_stop_bit", TxD, 1'b1);
                    check("rx_frame_expected", (exp_q.size() > 0), 1'b1);
                    if (exp_q.size() > 0) check("rx_byte", rx_byte, exp_q.pop_front());
                    rx_frames++;
                    rx_on = 0;
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Called at a negedge; waits (bounded) for !busy, then pulses send for one cycle.
    task automatic send_word(input logic [31:0] w);
        int t = 0;
        while (busy !== 1'b0 && t < 5000) begin @(negedge clk); t++; end
        check("send_wait_idle", busy, 1'b0);
        word = w;
        send = 1'b1;
        push_word(w);
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 5000) begin @(negedge clk); n++; end
    endtask

    initial begin
        int n;
        int idle_bad;
        logic [671:0] sr;

        rst_n = 1'b0;
        send  = 1'b0;
        word  = '0;
        repeat (3) @(negedge clk);
        check("reset_txd", TxD, 1'b1);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;

        // idle line stays high with no send
        idle_bad = 0;
        repeat (60) begin @(negedge clk); if (TxD !== 1'b1 || busy !== 1'b0) idle_bad++; end
        check("idle_line", idle_bad, 0);

        // basic word, latency and duration
        send_word(32'h0000_07ff);
        check("start_busy", busy, 1'b1);
        check("start_txd", TxD, 1'b0);
        measure_busy(n);
        check("word_len", n, WORD_CYC);

        // ignored send mid-word
        send_word(32'h1234_5678);
        repeat (99) @(negedge clk);
        word = 32'hDEAD_BEEF;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        measure_busy(n);
        check("ignored_send_len", n + 100, WORD_CYC);
        repeat (40) @(negedge clk);
        check("ignored_send_no_frame", busy, 1'b0);
        check("ignored_send_queue", exp_q.size(), 0);

        // send held for two cycles from idle
        word = 32'hC001_D00D;
        send = 1'b1;
        push_word(word);
        @(negedge clk);
        @(negedge clk);
        send = 1'b0;
        measure_busy(n);
        check("held_send_len", n + 1, WORD_CYC);
        repeat (40) @(negedge clk);
        check("held_send_no_repeat", busy, 1'b0);

        // back-to-back: 21 words from a 672-bit work unit, one-cycle gaps
        for (int i = 0; i < 21; i++) sr[i*32 +: 32] = $urandom;
        n = rx_frames;
        for (int i = 0; i < 21; i++) begin
            int len;
            send_word(sr[671 -: 32]);
            sr = {sr[639:0], 32'h0};
            measure_busy(len);
            check("b2b_len", len, WORD_CYC);
        end
        repeat (20) @(negedge clk);
        check("b2b_frames", rx_frames - n, 84);
        check("b2b_queue_empty", exp_q.size(), 0);

        // reset during byte 2 data bits
        send_word(32'hA5C3_0F96);
        repeat (2 * (WORD_CYC / 4) + CPB + 20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_txd", TxD, 1'b1);
        check("midreset_busy", busy, 1'b0);
        dropped += exp_q.size();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(32'h3C5A_F00F);
        measure_busy(n);
        check("post_reset_len", n, WORD_CYC);

`ifdef SERIAL_TX_PARITY_EN
        send_word(32'h0103_0700);
        measure_busy(n);
        check("parity_word_len", n, 44 * CPB);
`endif

        repeat (20) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_idle_txd", TxD, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
